// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS data-memory arbiter: FSM encoding and lock limit.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_LOCK1 = 2'd3
  } arb_state_e;

  localparam int unsigned LOCK_MAX   = 16;
  localparam int unsigned LOCK_CNT_W = 4;
  localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_MAX - 1);

endpackage

// File: rtl/mips_dmem_arbiter.sv
// Two-master arbiter (CPU data port m0, debug/DMA port m1) in front of a
// single-port synchronous RAM with one-cycle read latency.
module mips_dmem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wd,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wd,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic              m0_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  arb_state_e            state_q, state_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic                  tag_valid_q, tag_valid_d;
  logic                  tag_owner_q, tag_owner_d;
  logic [DATA_W-1:0]     m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]     m1_rdata_q, m1_rdata_d;
  logic                  gnt0_s, gnt1_s, lock_hold_s;

  // Arbitration and next-state: a live lock pre-empts round-robin until released or expired.
  always_comb begin
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    lock_hold_s = (state_q == ST_LOCK1) && m1_req && m1_lock;
    if (lock_hold_s) begin
      gnt1_s = 1'b1;
      if (lock_cnt_q == LOCK_LAST) begin
        state_d    = ST_OWN1;
        lock_cnt_d = '0;
      end else begin
        state_d    = ST_LOCK1;
        lock_cnt_d = lock_cnt_q + 4'd1;
      end
    end else begin
      // Leaving LOCK1 behaves like OWN1, so only OWN0 hands contention to m1.
      if (m0_req && m1_req) begin
        if (state_q == ST_OWN0) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b1;
        end
      end else begin
        gnt0_s = m0_req;
        gnt1_s = m1_req;
      end
      lock_cnt_d = '0;
      if (gnt0_s) begin
        state_d = ST_OWN0;
      end else if (gnt1_s) begin
        if (m1_lock) begin
          state_d    = ST_LOCK1;
          lock_cnt_d = 4'd1;
        end else begin
          state_d = ST_OWN1;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Output steering, read-tag capture and read-data routing; reset silences everything.
  always_comb begin
    m0_gnt    = gnt0_s & ~rst;
    m1_gnt    = gnt1_s & ~rst;
    m0_stall  = m0_req & ~m0_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wd    = '0;
    if (m0_gnt) begin
      mem_we   = m0_we;
      mem_addr = m0_addr;
      mem_wd   = m0_wd;
    end else if (m1_gnt) begin
      mem_we   = m1_we;
      mem_addr = m1_addr;
      mem_wd   = m1_wd;
    end else begin
      mem_we   = 1'b0;
    end
    tag_valid_d = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
    tag_owner_d = m1_gnt;
    m0_rvalid   = tag_valid_q & ~tag_owner_q & ~rst;
    m1_rvalid   = tag_valid_q & tag_owner_q & ~rst;
    if (rst) begin
      m0_rdata = '0;
      m1_rdata = '0;
    end else begin
      m0_rdata = m0_rvalid ? mem_rd : m0_rdata_q;
      m1_rdata = m1_rvalid ? mem_rd : m1_rdata_q;
    end
    m0_rdata_d = m0_rdata;
    m1_rdata_d = m1_rdata;
  end

  // State, lock counter, read tag and held read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lock_cnt_q  <= '0;
      tag_valid_q <= 1'b0;
      tag_owner_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

endmodule
